// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU increment sequencer: state encoding and
// default operand / repeat-count widths.
package alsu_pkg;

    localparam int ALSU_WIDTH = 4;
    localparam int ALSU_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alsu_state_e;

endpackage

// File: rtl/alsu_inc_sequencer.sv
// Drives an external incrementer N times on a selected operand and returns
// the final value plus a sticky wrap flag through a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | one increment per edge, remaining counts down to 1
// DONE  | result held on res_data/res_wrap until res_ready
module alsu_inc_sequencer
    import alsu_pkg::*;
#(
    parameter int WIDTH = ALSU_WIDTH,
    parameter int CNT_W = ALSU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_sel,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] inc_a,
    output logic [WIDTH-1:0] inc_b,
    output logic             inc_sel,
    input  logic [WIDTH-1:0] inc_out,
    input  logic             inc_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_wrap,
    output logic             busy
);

    alsu_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
        end
    end

    // Remaining is a down-counter; the RUN exit fires on terminal count 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sel_d  = sel_q;
        rem_d  = rem_q;
        wrap_d = wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a_d    = cmd_a;
                    b_d    = cmd_b;
                    sel_d  = cmd_sel;
                    rem_d  = cmd_count;
                    wrap_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (sel_q) begin
                    b_d = inc_out;
                end else begin
                    a_d = inc_out;
                end
                wrap_d = wrap_q | inc_carry;
                rem_d  = rem_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        res_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        inc_a     = a_q;
        inc_b     = b_q;
        inc_sel   = sel_q;
        res_data  = sel_q ? b_q : a_q;
        res_wrap  = wrap_q;
    end

endmodule

// File: tb/tb_alsu_inc_sequencer.sv
// Bench for alsu_inc_sequencer: closes the loop through a behavioural
// incrementer and checks results against (operand + N) arithmetic.
module tb_alsu_inc_sequencer;

    localparam int W = 4;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         cmd_sel = 1'b0;
    logic [C-1:0] cmd_count = '0;
    logic [W-1:0] inc_a, inc_b;
    logic         inc_sel;
    logic [W-1:0] inc_out;
    logic         inc_carry;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_wrap;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Stand-in for the integration-level incrementer.
    assign {inc_carry, inc_out} = (inc_sel ? {1'b0, inc_b} : {1'b0, inc_a}) + 5'd1;

    alsu_inc_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_count(cmd_count),
        .inc_a(inc_a), .inc_b(inc_b), .inc_sel(inc_sel),
        .inc_out(inc_out), .inc_carry(inc_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_wrap(res_wrap), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_wrap"}, res_wrap, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_inc_a"}, inc_a, 0);
        chk({tag, "_inc_b"}, inc_b, 0);
        chk({tag, "_inc_sel"}, inc_sel, 0);
    endtask

    // One command: accept, count edges to res_valid, check result, hold
    // res_ready low for 'hold' cycles while offering a bogus command, handshake.
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sel, input logic [C-1:0] n, input int hold);
        int           lat;
        int           sum;
        logic [W-1:0] exp_data;
        logic         exp_wrap;
        logic [W-1:0] other;
        sum      = (sel ? int'(b) : int'(a)) + int'(n);
        exp_data = W'(sum % (1 << W));
        exp_wrap = (sum >= (1 << W));
        other    = sel ? a : b;

        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_count = n;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_low_after_accept", cmd_ready, 0);

        lat = 0;
        while (!res_valid && lat < 40) begin
            chk("unselected_held", sel ? inc_a : inc_b, other);
            chk("inc_sel", inc_sel, sel);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, int'(n));
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, exp_data);
        chk("res_wrap", res_wrap, exp_wrap);
        chk("unselected_final", sel ? inc_a : inc_b, other);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_a     = W'($urandom);
            cmd_b     = W'($urandom);
            cmd_count = C'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_ready_low", cmd_ready, 0);
            chk("hold_data", res_data, exp_data);
            chk("hold_wrap", res_wrap, exp_wrap);
        end

        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_hs_valid", res_valid, 0);
        chk("post_hs_ready", cmd_ready, 1);
        chk("post_hs_busy", busy, 0);
    endtask

    initial begin
        int seen_valid;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("after_release");

        run_cmd(4'd3, 4'd0, 1'b0, 4'd1, 0);
        run_cmd(4'd0, 4'd14, 1'b1, 4'd3, 0);
        run_cmd(4'd15, 4'd0, 1'b0, 4'd0, 0);
        run_cmd(4'd15, 4'd5, 1'b0, 4'd15, 5);

        // Reset mid-RUN: A=2, N=10, four edges in.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = 4'd2;
        cmd_b     = 4'd7;
        cmd_sel   = 1'b0;
        cmd_count = 4'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen_valid++;
        end
        chk("no_result_after_abort", seen_valid, 0);
        run_cmd(4'd2, 4'd9, 1'b1, 4'd10, 1);

        // Back-to-back randomized commands with res_ready asserted promptly.
        for (int k = 0; k < 24; k++) begin
            run_cmd(W'($urandom), W'($urandom), 1'($urandom),
                    C'($urandom), (k % 4 == 3) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
